// File: rtl/pingpong_pkg.sv
// Shared constants, width helper and producer-policy encoding for the row buffer.
package pingpong_pkg;

  localparam int unsigned PP_DATA_W    = 24;
  localparam int unsigned PP_ROW_LEN   = 8;
  localparam int unsigned PP_NUM_BANKS = 2;

  // Producer policy when the bank under the write pointer is still full.
  localparam int unsigned PP_MODE_DROP  = 0;
  localparam int unsigned PP_MODE_STALL = 1;

  // Index width for a power-of-two count; never narrower than one bit.
  function automatic int unsigned pp_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pp_bank.sv
// One row bank: ROW_LEN words written serially, read back all at once.
module pp_bank
  import pingpong_pkg::*;
#(
  parameter int unsigned DATA_W  = PP_DATA_W,
  parameter int unsigned ROW_LEN = PP_ROW_LEN
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [pp_width(ROW_LEN)-1:0]  wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [ROW_LEN*DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem_q [ROW_LEN];
  logic [DATA_W-1:0] mem_d [ROW_LEN];

  // Write one word at the fill index when enabled.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage holds pixel data only, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Flatten the row: word k sits at bits [k*DATA_W +: DATA_W].
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(ROW_LEN); k++) begin
      rd_data[k*DATA_W +: DATA_W] = mem_q[k];
    end
  end

endmodule

// File: rtl/pingpong_row_buffer.sv
// Multi-bank row buffer: serial pixel words in, whole rows out to the DCT.
module pingpong_row_buffer
  import pingpong_pkg::*;
#(
  parameter int unsigned DATA_W     = PP_DATA_W,
  parameter int unsigned ROW_LEN    = PP_ROW_LEN,
  parameter int unsigned NUM_BANKS  = PP_NUM_BANKS,
  parameter int unsigned STALL_MODE = PP_MODE_STALL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [ROW_LEN*DATA_W-1:0]      out_data,
  output logic [pp_width(NUM_BANKS)-1:0] out_bank,
  input  logic                           out_ready,
  output logic                           overflow
);

  localparam int unsigned PTR_W    = pp_width(NUM_BANKS);
  localparam int unsigned CNT_W    = pp_width(ROW_LEN);
  localparam int unsigned ROW_W    = ROW_LEN * DATA_W;
  localparam bit          STALL_EN = (STALL_MODE == PP_MODE_STALL);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fill_cnt_q, fill_cnt_d;
  logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
  logic                 overflow_q, overflow_d;

  logic                 wr_full_c;
  logic                 rd_full_c;
  logic                 write_c;
  logic                 last_c;
  logic                 drop_c;
  logic                 release_c;
  logic [NUM_BANKS-1:0] bank_we_c;
  logic [ROW_W-1:0]     bank_rd [NUM_BANKS];

  // Handshake decode; every term comes from registered state or the current inputs.
  always_comb begin
    wr_full_c = bank_full_q[wr_ptr_q];
    rd_full_c = bank_full_q[rd_ptr_q];
    // A full bank is never written, whichever policy is selected.
    write_c   = in_valid & ~wr_full_c & ~clear;
    last_c    = write_c & (fill_cnt_q == CNT_W'(ROW_LEN - 1));
    drop_c    = in_valid & wr_full_c & ~clear & ~STALL_EN;
    release_c = rd_full_c & out_ready & ~clear;
  end

  // Per-bank write enable from the write pointer.
  always_comb begin
    bank_we_c = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      bank_we_c[b] = write_c & (wr_ptr_q == PTR_W'(b));
    end
  end

  // Next-state for pointers, fill count, full flags and the sticky overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    bank_full_d = bank_full_q;
    overflow_d  = overflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fill_cnt_d  = '0;
      bank_full_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (write_c) begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
      // Completing a row and releasing another bank can land on the same edge.
      if (last_c) begin
        bank_full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (release_c) begin
        bank_full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d              = rd_ptr_q + PTR_W'(1);
      end
      if (drop_c) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      bank_full_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Bank storage, one instance per bank.
  for (genvar g = 0; g < int'(NUM_BANKS); g++) begin : g_bank
    pp_bank #(
      .DATA_W  (DATA_W),
      .ROW_LEN (ROW_LEN)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we_c[g]),
      .wr_idx  (fill_cnt_q),
      .wr_data (in_data),
      .rd_data (bank_rd[g])
    );
  end

  // Outputs decode registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = STALL_EN ? ~wr_full_c : 1'b1;
    out_valid = rd_full_c;
    out_bank  = rd_ptr_q;
    out_data  = bank_rd[rd_ptr_q];
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_pingpong_row_buffer.sv
// Bench for pingpong_row_buffer: three configurations against a row-level reference model.
module tb_pingpong_row_buffer;

  logic clk;
  logic rst;

  // Instance A: defaults (24-bit, 8 words, 2 banks, stall).
  logic         a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_overflow;
  logic [23:0]  a_in_data;
  logic [191:0] a_out_data;
  logic [0:0]   a_out_bank;
  // Instance B: drop policy, 2 banks.
  logic         b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow;
  logic [23:0]  b_in_data;
  logic [191:0] b_out_data;
  logic [0:0]   b_out_bank;
  // Instance C: 12-bit, 4 words, 4 banks, stall.
  logic         c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_overflow;
  logic [11:0]  c_in_data;
  logic [47:0]  c_out_data;
  logic [1:0]   c_out_bank;

  pingpong_row_buffer u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_bank(a_out_bank), .out_ready(a_out_ready), .overflow(a_overflow)
  );

  pingpong_row_buffer #(.STALL_MODE(0)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_bank(b_out_bank), .out_ready(b_out_ready), .overflow(b_overflow)
  );

  pingpong_row_buffer #(.DATA_W(12), .ROW_LEN(4), .NUM_BANKS(4), .STALL_MODE(1)) u_c (
    .clk(clk), .rst(rst), .clear(c_clear), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_bank(c_out_bank), .out_ready(c_out_ready), .overflow(c_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-instance configuration.
  int LEN   [3] = '{8, 8, 4};
  int BANKS [3] = '{2, 2, 4};
  int WID   [3] = '{24, 24, 12};
  bit STALL [3] = '{1'b1, 1'b0, 1'b1};

  // Reference model: words written so far, rows released so far, sticky overflow.
  logic [23:0] m_mem [3][4096];
  int          m_acc [3];
  int          m_rel [3];
  bit          m_ovf [3];

  // Observed and expected values for the cycle just stepped.
  bit          s_ir, s_ov, s_of, e_ir, e_ov, e_of;
  int          s_bank, e_bank;
  logic [23:0] s_word [8];
  logic [23:0] e_word [8];
  bit          acc_flag;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_rel[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    a_clear = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_clear = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
  endtask

  // One clock on instance id: drive at the falling edge, sample, predict, advance the model.
  task automatic step(input int id, input bit v, input logic [23:0] d, input bit r, input bit clr);
    int          outst;
    logic [23:0] mask;
    idle_inputs();
    case (id)
      0: begin a_in_valid = v; a_in_data = d; a_out_ready = r; a_clear = clr; end
      1: begin b_in_valid = v; b_in_data = d; b_out_ready = r; b_clear = clr; end
      default: begin c_in_valid = v; c_in_data = d[11:0]; c_out_ready = r; c_clear = clr; end
    endcase
    #1;
    for (int k = 0; k < 8; k++) s_word[k] = '0;
    case (id)
      0: begin
        s_ir = a_in_ready; s_ov = a_out_valid; s_of = a_overflow; s_bank = int'(a_out_bank);
        for (int k = 0; k < 8; k++) s_word[k] = a_out_data[k*24 +: 24];
      end
      1: begin
        s_ir = b_in_ready; s_ov = b_out_valid; s_of = b_overflow; s_bank = int'(b_out_bank);
        for (int k = 0; k < 8; k++) s_word[k] = b_out_data[k*24 +: 24];
      end
      default: begin
        s_ir = c_in_ready; s_ov = c_out_valid; s_of = c_overflow; s_bank = int'(c_out_bank);
        for (int k = 0; k < 4; k++) s_word[k] = 24'(c_out_data[k*12 +: 12]);
      end
    endcase
    mask  = 24'((64'd1 << WID[id]) - 64'd1);
    // Rows completed minus rows released = rows waiting in the buffer.
    outst = m_acc[id] / LEN[id] - m_rel[id];
    e_ov   = (outst > 0);
    e_ir   = STALL[id] ? (outst < BANKS[id]) : 1'b1;
    e_of   = m_ovf[id];
    e_bank = m_rel[id] % BANKS[id];
    for (int k = 0; k < 8; k++)
      e_word[k] = (k < LEN[id]) ? m_mem[id][m_rel[id]*LEN[id] + k] : 24'h0;
    acc_flag = 1'b0;
    if (clr) begin
      m_acc[id] = 0; m_rel[id] = 0; m_ovf[id] = 1'b0;
    end else begin
      if (v && outst < BANKS[id]) begin
        m_mem[id][m_acc[id]] = d & mask;
        m_acc[id]++;
        acc_flag = 1'b1;
      end else if (v && !STALL[id]) begin
        m_ovf[id] = 1'b1;
      end
      if (e_ov && r) m_rel[id]++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_all();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_all();
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_a got=%b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_a got=%b exp=0", a_out_valid); end
    checks++; if (a_out_bank !== 1'b0) begin errors++; $display("FAIL rst_out_bank_a got=%0d exp=0", a_out_bank); end
    checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow_b got=%b exp=0", b_overflow); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_b got=%b exp=1", b_in_ready); end
    checks++; if (c_out_bank !== 2'd0) begin errors++; $display("FAIL rst_out_bank_c got=%0d exp=0", c_out_bank); end
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_c got=%b exp=0", c_out_valid); end
    @(negedge clk);
  endtask

  // Words 1..16 with out_ready high: rows appear in cycles 9 and 17, in_ready never drops.
  task automatic test_stream();
    reset_all();
    for (int i = 1; i <= 20; i++) begin
      step(0, i <= 16, 24'(i), 1'b1, 1'b0);
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", i, s_ir, e_ir); end
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%b", i, s_ov, e_ov); end
      if (e_ov) begin
        checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL stream_out_bank cyc=%0d got=%0d exp=%0d", i, s_bank, e_bank); end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (s_word[k] !== e_word[k]) begin errors++; $display("FAIL stream_word%0d cyc=%0d got=%0h exp=%0h", k, i, s_word[k], e_word[k]); end
        end
      end
    end
  endtask

  // Both banks full with out_ready low; one release lets the producer resume without loss.
  task automatic test_back_pressure();
    int w = 1;
    int cyc = 0;
    reset_all();
    while (w <= 16 && cyc < 100) begin
      step(0, 1'b1, 24'(w), 1'b0, 1'b0);
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL bp_fill_in_ready w=%0d got=%b exp=%b", w, s_ir, e_ir); end
      if (acc_flag) w++;
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 24'(w), 1'b0, 1'b0);
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL bp_stall_in_ready got=%b exp=%b", s_ir, e_ir); end
    end
    step(0, 1'b1, 24'(w), 1'b1, 1'b0);
    checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=%b", s_ir, e_ir); end
    checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL bp_release_valid got=%b exp=%b", s_ov, e_ov); end
    checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL bp_release_bank got=%0d exp=%0d", s_bank, e_bank); end
    cyc = 0;
    while (w <= 24 && cyc < 100) begin
      step(0, 1'b1, 24'(w), 1'b0, 1'b0);
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL bp_resume_in_ready w=%0d got=%b exp=%b", w, s_ir, e_ir); end
      if (acc_flag) w++;
      cyc++;
    end
    checks++; if (w != 25) begin errors++; $display("FAIL bp_resume_budget got=%0d exp=25", w); end
    for (int i = 0; i < 6; i++) begin
      step(0, 1'b0, 24'h0, 1'b1, 1'b0);
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL bp_drain_valid i=%0d got=%b exp=%b", i, s_ov, e_ov); end
      if (e_ov) begin
        checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL bp_drain_bank got=%0d exp=%0d", s_bank, e_bank); end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (s_word[k] !== e_word[k]) begin errors++; $display("FAIL bp_drain_word%0d got=%0h exp=%0h", k, s_word[k], e_word[k]); end
        end
      end
    end
  endtask

  // Drop policy: 17th word is discarded and overflow sticks until a clear.
  task automatic test_drop_overflow();
    reset_all();
    for (int i = 1; i <= 21; i++) begin
      step(1, i <= 17, 24'(i), 1'b0, 1'b0);
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL drop_in_ready i=%0d got=%b exp=%b", i, s_ir, e_ir); end
      checks++; if (s_of !== e_of) begin errors++; $display("FAIL drop_overflow i=%0d got=%b exp=%b", i, s_of, e_of); end
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL drop_out_valid i=%0d got=%b exp=%b", i, s_ov, e_ov); end
    end
    step(1, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1, 1'b0, 24'h0, 1'b0, 1'b0);
      checks++; if (s_of !== e_of) begin errors++; $display("FAIL drop_clear_overflow got=%b exp=%b", s_of, e_of); end
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL drop_clear_valid got=%b exp=%b", s_ov, e_ov); end
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL drop_clear_in_ready got=%b exp=%b", s_ir, e_ir); end
    end
  endtask

  // Four banks with random gaps and throttling: rows must come out in order and intact.
  task automatic test_random_4bank();
    int cyc = 0;
    reset_all();
    while (m_acc[2] < 200 && cyc < 3000) begin
      step(2, ($urandom % 4) != 0, 24'($urandom), ($urandom % 2) == 1, 1'b0);
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, s_ir, e_ir); end
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, s_ov, e_ov); end
      if (e_ov) begin
        checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL rnd_out_bank cyc=%0d got=%0d exp=%0d", cyc, s_bank, e_bank); end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (s_word[k] !== e_word[k]) begin errors++; $display("FAIL rnd_word%0d cyc=%0d got=%0h exp=%0h", k, cyc, s_word[k], e_word[k]); end
        end
      end
      cyc++;
    end
    checks++; if (m_acc[2] < 200) begin errors++; $display("FAIL rnd_budget got=%0d exp=200", m_acc[2]); end
    for (int i = 0; i < 60; i++) begin
      step(2, 1'b0, 24'h0, ($urandom % 2) == 1, 1'b0);
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL rnd_drain_valid i=%0d got=%b exp=%b", i, s_ov, e_ov); end
      if (e_ov) begin
        checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL rnd_drain_bank got=%0d exp=%0d", s_bank, e_bank); end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (s_word[k] !== e_word[k]) begin errors++; $display("FAIL rnd_drain_word%0d got=%0h exp=%0h", k, s_word[k], e_word[k]); end
        end
      end
    end
    checks++; if (m_rel[2] != 50) begin errors++; $display("FAIL rnd_rows_released got=%0d exp=50", m_rel[2]); end
  endtask

  // Asynchronous reset mid-row returns state at once; the next row restarts in bank 0.
  task automatic test_async_reset();
    reset_all();
    for (int i = 1; i <= 17; i++) step(1, 1'b1, 24'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) step(0, 1'b1, 24'(i), 1'b0, 1'b0);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got=%b exp=0", b_overflow); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, i < 8, 24'(24'h100 + i), 1'b0, 1'b0);
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL arst_refill_valid i=%0d got=%b exp=%b", i, s_ov, e_ov); end
      if (e_ov) begin
        checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL arst_refill_bank got=%0d exp=%0d", s_bank, e_bank); end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (s_word[k] !== e_word[k]) begin errors++; $display("FAIL arst_refill_word%0d got=%0h exp=%0h", k, s_word[k], e_word[k]); end
        end
      end
    end
  endtask

  // Clear together with the 8th word and out_ready: the word is lost and no row completes.
  task automatic test_clear_priority();
    reset_all();
    for (int i = 1; i <= 7; i++) step(0, 1'b1, 24'(i), 1'b0, 1'b0);
    step(0, 1'b1, 24'd8, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 24'h0, 1'b0, 1'b0);
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL clr_out_valid got=%b exp=%b", s_ov, e_ov); end
      checks++; if (s_ir !== e_ir) begin errors++; $display("FAIL clr_in_ready got=%b exp=%b", s_ir, e_ir); end
    end
    for (int i = 0; i < 9; i++) begin
      step(0, i < 8, 24'(24'h50 + i), 1'b0, 1'b0);
      checks++; if (s_ov !== e_ov) begin errors++; $display("FAIL clr_refill_valid i=%0d got=%b exp=%b", i, s_ov, e_ov); end
      if (e_ov) begin
        checks++; if (s_bank !== e_bank) begin errors++; $display("FAIL clr_refill_bank got=%0d exp=%0d", s_bank, e_bank); end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (s_word[k] !== e_word[k]) begin errors++; $display("FAIL clr_refill_word%0d got=%0h exp=%0h", k, s_word[k], e_word[k]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_stream();
    test_back_pressure();
    test_drop_overflow();
    test_random_4bank();
    test_async_reset();
    test_clear_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
